// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Run/step/halt controller for a five-stage pipeline. Drives the
//               stage-register enables, the IF/ID flush and the ID/EX bubble,
//               handles load-use stalls and taken-branch flushes, and drains
//               in-flight instructions for DRAIN_CYCLES cycles after a HALT
//               before parking in HALTED. Counts active cycles (saturating).
// Ports       : clk             - clock, all state on rising edge
//               i_rst           - synchronous active-high reset
//               i_run           - level, start continuous execution from IDLE
//               i_step          - pulse, execute exactly one cycle from IDLE
//               i_halt_instr    - HALT decoded in ID this cycle
//               i_load_use      - load-use hazard this cycle
//               i_flush_req     - taken jump/branch resolved in ID this cycle
//               o_pc_en .. o_mem_wb_en - stage register enables
//               o_if_id_flush   - clear IF/ID to NOP on next edge
//               o_id_ex_bubble  - load NOP control into ID/EX on next edge
//               o_halted        - high in HALTED
//               o_busy          - high in RUN, STEP or DRAIN
//               o_cycle_cnt     - saturating active-cycle count (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_halt_instr,
  input  logic              i_load_use,
  input  logic              i_flush_req,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_id_ex_en,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_halted,
  output logic              o_busy,
  output logic [NB_CNT-1:0] o_cycle_cnt
);

  // Drain counter holds DRAIN_CYCLES-1 down to 0; at least one bit wide so
  // DRAIN_CYCLES=1 still elaborates.
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]     state;
  logic [2:0]     state_next;
  logic [DCW-1:0] drain_cnt;
  logic [DCW-1:0] drain_cnt_next;

  // State register, drain counter and active-cycle counter.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      o_cycle_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      // Saturate at all-ones instead of wrapping.
      if (o_busy && (o_cycle_cnt != '1)) begin
        o_cycle_cnt <= o_cycle_cnt + NB_CNT'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      S_IDLE: begin
        if (i_run) begin
          state_next = S_RUN;
        end else if (i_step) begin
          state_next = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        // A load-use stall masks the HALT; the HALT is re-decoded once the
        // stall clears. A stalled STEP still consumes the step.
        if (!i_load_use && i_halt_instr) begin
          state_next     = S_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else if (state == S_STEP) begin
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = S_HALTED;
        end else begin
          drain_cnt_next = drain_cnt - DCW'(1);
        end
      end
      S_HALTED: begin
        state_next = S_HALTED;
      end
      default: begin
        state_next     = S_IDLE;
        drain_cnt_next = '0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_id_ex_en     = 1'b0;
    o_ex_mem_en    = 1'b0;
    o_mem_wb_en    = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_halted       = 1'b0;
    o_busy         = 1'b0;
    case (state)
      S_RUN, S_STEP: begin
        o_busy      = 1'b1;
        o_id_ex_en  = 1'b1;
        o_ex_mem_en = 1'b1;
        o_mem_wb_en = 1'b1;
        if (i_load_use) begin
          // Freeze PC and IF/ID, inject a bubble behind the load.
          o_id_ex_bubble = 1'b1;
        end else if (i_halt_instr) begin
          // Stop fetching; the HALT itself moves on down the pipe.
          o_pc_en    = 1'b0;
          o_if_id_en = 1'b0;
        end else begin
          o_pc_en       = 1'b1;
          o_if_id_en    = 1'b1;
          o_if_id_flush = i_flush_req;
        end
      end
      S_DRAIN: begin
        o_busy         = 1'b1;
        o_id_ex_en     = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_id_ex_bubble = 1'b1;
      end
      S_HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire
